// File: rtl/ps2_pkg.sv
// PS/2 shared definitions.
// Used by the host transmitter and the keyboard receiver.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      SEND,
      ACK,
      WAIT_IDLE
   } ps2_state_e;

   localparam int PS2_FRAME_BITS = 10;

   function automatic int us_to_cycles(input longint clk_hz, input longint us);
      return int'((clk_hz * us) / 1_000_000);
   endfunction

endpackage

// File: rtl/ps2_host_tx_edge_sync.sv
// 2-FF synchronizer for the PS/2 clock and data pins.
// Also flags a falling edge of the synced clock.
module ps2_edge_sync (
   input  logic Clk,
   input  logic Rst,
   input  logic clk_i,
   input  logic data_i,
   output logic clk_o,
   output logic data_o,
   output logic fall_o
);

   logic [1:0] clk_q, clk_d;
   logic [1:0] data_q, data_d;
   logic       prev_q;

   assign clk_d  = {clk_q[0], clk_i};
   assign data_d = {data_q[0], data_i};

   // Idle bus is high, so the chain resets to 1.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         clk_q  <= 2'b11;
         data_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         clk_q  <= clk_d;
         data_q <= data_d;
         prev_q <= clk_q[1];
      end
   end

   assign clk_o  = clk_q[1];
   assign data_o = data_q[1];
   assign fall_o = prev_q & ~clk_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Drives key_clk/key_data open-drain via output enables.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int INHIBIT_CYCLES = us_to_cycles(CLK_HZ, 100),
   parameter int RTS_CYCLES     = 8,
   parameter int TIMEOUT_CYCLES = us_to_cycles(CLK_HZ, 15_000)
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   output logic       rx_inhibit,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ?
                          INHIBIT_CYCLES : RTS_CYCLES;
   localparam int MAXC  = (MAX_A > TIMEOUT_CYCLES) ?
                          MAX_A : TIMEOUT_CYCLES;
   localparam int CW    = $clog2(MAXC + 1);

   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [3:0]    IDX_LAST = 4'(PS2_FRAME_BITS - 1);

   ps2_state_e                state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
   logic [3:0]                idx_q, idx_d;
   logic                      doe_q, doe_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;

   logic clk_s, data_s, fall;
   logic timed;

   ps2_edge_sync u_sync (
      .Clk    (Clk),
      .Rst    (Rst),
      .clk_i  (ps2_clk_in),
      .data_i (ps2_data_in),
      .clk_o  (clk_s),
      .data_o (data_s),
      .fall_o (fall)
   );

   // State, frame, counter and pulse registers.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         frame_q <= '1;
         idx_q   <= '0;
         doe_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         idx_q   <= idx_d;
         doe_q   <= doe_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign timed = (state_q == SEND) || (state_q == ACK) ||
                  (state_q == WAIT_IDLE);

   // Next state, including the shared counter and frame shifter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      idx_d   = idx_q;
      doe_d   = doe_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      if (timed) begin
         if (fall) begin
            cnt_d = '0;
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      unique case (state_q)
         IDLE: begin
            doe_d = 1'b0;
            if (tx_valid) begin
               frame_d = {1'b1, ~^tx_data, tx_data};
               idx_d   = '0;
               cnt_d   = '0;
               state_d = INHIBIT;
            end
         end
         INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               cnt_d   = '0;
               doe_d   = 1'b1;
               state_d = RTS;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RTS: begin
            if (cnt_q == RTS_LAST) begin
               cnt_d   = '0;
               state_d = SEND;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         SEND: begin
            if (fall) begin
               doe_d   = ~frame_q[0];
               frame_d = {1'b1, frame_q[PS2_FRAME_BITS-1:1]};
               idx_d   = idx_q + 4'd1;
               if (idx_q == IDX_LAST) begin
                  state_d = ACK;
               end
            end
         end
         ACK: begin
            if (fall) begin
               if (!data_s) begin
                  state_d = WAIT_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (clk_s && data_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (timed && !fall && (cnt_q == TO_LAST)) begin
         state_d = IDLE;
         doe_d   = 1'b0;
         done_d  = 1'b0;
         err_d   = 1'b1;
      end
   end

   // Outputs decoded from the current state.
   always_comb begin
      tx_ready    = (state_q == IDLE);
      rx_inhibit  = (state_q != IDLE);
      ps2_clk_oe  = (state_q == INHIBIT) || (state_q == RTS);
      ps2_data_oe = doe_q;
      tx_done     = done_q;
      tx_err      = err_q;
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx.
// Device model clocks at a 40-cycle period, sampling on rising edge.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INH  = 5000;
   localparam int RTSC = 8;
   localparam int TO   = 1000;
   localparam int HP   = 20;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, tx_done, tx_err, rx_inhibit;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       ps2_clk_in, ps2_data_in;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   int err_cnt = 0;

   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   always #5 Clk = ~Clk;

   ps2_host_tx #(
      .CLK_HZ         (50_000_000),
      .INHIBIT_CYCLES (INH),
      .RTS_CYCLES     (RTSC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .tx_done     (tx_done),
      .tx_err      (tx_err),
      .rx_inhibit  (rx_inhibit),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   always @(negedge Clk) begin
      if (tx_done === 1'b1) done_cnt++;
      if (tx_err === 1'b1) err_cnt++;
   end

   task automatic send_req(input logic [7:0] b);
      @(negedge Clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge Clk);
      tx_valid = 1'b0;
   endtask

   task automatic dev_frame(input bit do_ack, input int abort_bit,
                            output logic [9:0] bits, output bit ok);
      int w;
      ok   = 1'b0;
      bits = '0;
      w    = 0;
      while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < 20000) begin
         @(negedge Clk);
         w++;
      end
      if (w >= 20000) return;
      ok = 1'b1;
      repeat (10) @(negedge Clk);
      for (int i = 0; i < 10; i++) begin
         dev_clk = 1'b0;
         repeat (HP) @(negedge Clk);
         if (i == abort_bit) return;
         dev_clk = 1'b1;
         bits[i] = ps2_data_in;
         repeat (HP) @(negedge Clk);
      end
      repeat (5) @(negedge Clk);
      dev_data = ~do_ack;
      repeat (5) @(negedge Clk);
      dev_clk = 1'b0;
      repeat (HP) @(negedge Clk);
      dev_clk = 1'b1;
      repeat (5) @(negedge Clk);
      dev_data = 1'b1;
   endtask

   task automatic test_reset();
      logic [9:0] bits;
      bit ok;
      int d0, e0;
      @(negedge Clk);
      #2 Rst = 1'b0;
      #1;
      vectors++;
      if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL idle_reset: clk_oe=%b data_oe=%b ready=%b, want 0 0 1",
                  ps2_clk_oe, ps2_data_oe, tx_ready);
      end
      @(negedge Clk);
      Rst = 1'b1;
      send_req(8'hED);
      dev_frame(1'b1, 4, bits, ok);
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_send_reach: ok=%b, want 1", ok);
      end
      vectors++;
      if (ps2_data_oe !== 1'b1) begin
         miscompares++;
         $display("FAIL bit4_drive: data_oe=%b, want 1", ps2_data_oe);
      end
      d0 = done_cnt;
      e0 = err_cnt;
      #2 Rst = 1'b0;
      #1;
      vectors++;
      if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
         miscompares++;
         $display("FAIL async_release: clk_oe=%b data_oe=%b, want 0 0",
                  ps2_clk_oe, ps2_data_oe);
      end
      dev_clk = 1'b1;
      @(negedge Clk);
      Rst = 1'b1;
      repeat (50) @(negedge Clk);
      vectors++;
      if (tx_ready !== 1'b1 || rx_inhibit !== 1'b0 ||
          done_cnt != d0 || err_cnt != e0) begin
         miscompares++;
         $display("FAIL after_reset: ready=%b inh=%b done+%0d err+%0d, want 1 0 0 0",
                  tx_ready, rx_inhibit, done_cnt - d0, err_cnt - e0);
      end
   endtask

   task automatic test_send_ed();
      logic [9:0] bits;
      bit ok;
      int n, m, d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send_req(8'hED);
      n = 0;
      while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < INH + 100) begin
         n++;
         @(negedge Clk);
      end
      vectors++;
      if (n != INH) begin
         miscompares++;
         $display("FAIL inhibit_len: got %0d cycles, want %0d", n, INH);
      end
      m = 0;
      while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && m < RTSC + 100) begin
         m++;
         @(negedge Clk);
      end
      vectors++;
      if (m != RTSC) begin
         miscompares++;
         $display("FAIL rts_len: got %0d cycles, want %0d", m, RTSC);
      end
      dev_frame(1'b1, -1, bits, ok);
      vectors++;
      if (ok !== 1'b1 || bits !== 10'h3ED) begin
         miscompares++;
         $display("FAIL frame_ed: ok=%b bits=%h, want 1 3ed", ok, bits);
      end
      n = 0;
      while (done_cnt == d0 && n < 200) begin
         @(negedge Clk);
         n++;
      end
      repeat (5) @(negedge Clk);
      vectors++;
      if (done_cnt - d0 != 1 || err_cnt != e0) begin
         miscompares++;
         $display("FAIL done_ed: done+%0d err+%0d, want 1 0",
                  done_cnt - d0, err_cnt - e0);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] bits;
      bit ok;
      int n, d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send_req(8'hF4);
      dev_frame(1'b1, -1, bits, ok);
      vectors++;
      if (ok !== 1'b1 || bits !== 10'h2F4) begin
         miscompares++;
         $display("FAIL frame_f4: ok=%b bits=%h, want 1 2f4", ok, bits);
      end
      n = 0;
      while (tx_done !== 1'b1 && n < 200) begin
         @(negedge Clk);
         n++;
      end
      vectors++;
      if (n >= 200 || tx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL done_f4: waited %0d ready=%b, want <200 1", n, tx_ready);
      end
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      @(negedge Clk);
      tx_valid = 1'b0;
      vectors++;
      if (rx_inhibit !== 1'b1) begin
         miscompares++;
         $display("FAIL accept_on_done: inh=%b, want 1", rx_inhibit);
      end
      dev_frame(1'b1, -1, bits, ok);
      vectors++;
      if (ok !== 1'b1 || bits !== 10'h3FF) begin
         miscompares++;
         $display("FAIL frame_ff: ok=%b bits=%h, want 1 3ff", ok, bits);
      end
      n = 0;
      while (done_cnt - d0 < 2 && n < 200) begin
         @(negedge Clk);
         n++;
      end
      repeat (5) @(negedge Clk);
      vectors++;
      if (done_cnt - d0 != 2 || err_cnt != e0) begin
         miscompares++;
         $display("FAIL done_b2b: done+%0d err+%0d, want 2 0",
                  done_cnt - d0, err_cnt - e0);
      end
   endtask

   task automatic test_nack();
      logic [9:0] bits;
      bit ok;
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send_req(8'h5A);
      dev_frame(1'b0, -1, bits, ok);
      repeat (10) @(negedge Clk);
      vectors++;
      if (ok !== 1'b1 || bits !== 10'h35A) begin
         miscompares++;
         $display("FAIL frame_5a: ok=%b bits=%h, want 1 35a", ok, bits);
      end
      vectors++;
      if (err_cnt - e0 != 1 || done_cnt != d0) begin
         miscompares++;
         $display("FAIL nack_pulse: err+%0d done+%0d, want 1 0",
                  err_cnt - e0, done_cnt - d0);
      end
      vectors++;
      if (tx_ready !== 1'b1 || rx_inhibit !== 1'b0 ||
          ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
         miscompares++;
         $display("FAIL nack_idle: ready=%b inh=%b clk_oe=%b data_oe=%b, want 1 0 0 0",
                  tx_ready, rx_inhibit, ps2_clk_oe, ps2_data_oe);
      end
   endtask

   task automatic test_timeout();
      int n, t, d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send_req(8'hFF);
      n = 0;
      while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 6000) begin
         @(negedge Clk);
         n++;
      end
      t = 0;
      while (tx_err !== 1'b1 && t < TO + 100) begin
         @(negedge Clk);
         t++;
      end
      vectors++;
      if (n >= 6000 || t != TO) begin
         miscompares++;
         $display("FAIL timeout_len: got %0d cycles, want %0d", t, TO);
      end
      vectors++;
      if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_release: clk_oe=%b data_oe=%b ready=%b, want 0 0 1",
                  ps2_clk_oe, ps2_data_oe, tx_ready);
      end
      repeat (3) @(negedge Clk);
      vectors++;
      if (err_cnt - e0 != 1 || done_cnt != d0) begin
         miscompares++;
         $display("FAIL timeout_pulse: err+%0d done+%0d, want 1 0",
                  err_cnt - e0, done_cnt - d0);
      end
   endtask

   task automatic test_ignore_busy();
      logic [9:0] bits;
      bit ok;
      int n, bad, d0;
      d0  = done_cnt;
      bad = 0;
      n   = 0;
      tx_data = 8'hED;
      send_req(8'hED);
      fork
         dev_frame(1'b1, -1, bits, ok);
         begin
            repeat (125) begin
               repeat (40) @(negedge Clk);
               tx_data  = 8'h00;
               tx_valid = 1'b1;
               @(negedge Clk);
               tx_valid = 1'b0;
            end
         end
         begin
            while (tx_done !== 1'b1 && n < 20000) begin
               if (rx_inhibit !== 1'b1) bad++;
               @(negedge Clk);
               n++;
            end
         end
      join
      vectors++;
      if (ok !== 1'b1 || bits !== 10'h3ED) begin
         miscompares++;
         $display("FAIL frame_busy: ok=%b bits=%h, want 1 3ed", ok, bits);
      end
      vectors++;
      if (bad != 0 || n >= 20000) begin
         miscompares++;
         $display("FAIL inhibit_span: low cycles=%0d waited=%0d, want 0 <20000",
                  bad, n);
      end
      repeat (100) @(negedge Clk);
      vectors++;
      if (rx_inhibit !== 1'b0 || ps2_clk_oe !== 1'b0 || done_cnt - d0 != 1) begin
         miscompares++;
         $display("FAIL no_queue: inh=%b clk_oe=%b done+%0d, want 0 0 1",
                  rx_inhibit, ps2_clk_oe, done_cnt - d0);
      end
   endtask

   initial begin
      repeat (3) @(negedge Clk);
      Rst = 1'b1;
      repeat (5) @(negedge Clk);
      test_reset();
      test_send_ed();
      test_back_to_back();
      test_nack();
      test_timeout();
      test_ignore_busy();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
